// File: rtl/iob_native_split_pkg.sv
// iob_native_split_pkg: FSM encodings and default error read data for the native port splitter
package iob_native_split_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;
endpackage

// File: rtl/iob_native_split_timer.sv
// iob_native_split_timer: bus watchdog counting wait cycles, expiring on the last allowed one
module iob_native_split_timer #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [W-1:0] cnt;
  // count enabled cycles; held at zero when the watchdog is disabled
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt <= '0;
    else cnt <= (clr || TIMEOUT == 0) ? '0 : en ? cnt + 1'b1 : cnt;
  assign expire = TIMEOUT != 0 && en && cnt == LAST;
endmodule

// File: rtl/iob_native_split.sv
// iob_native_split: registered CPU native port splitter to one instruction port and N data ports
module iob_native_split import iob_native_split_pkg::*; #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int N_DPORTS  = 2,
  parameter int SEL_W     = 1,
  parameter int BOOT_PORT = 1,
  parameter int TIMEOUT   = 256,
  parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_RDATA_DEF)
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           boot,
  input  logic                           err_clr,
  input  logic                           cpu_valid,
  input  logic                           cpu_instr,
  input  logic [ADDR_W-1:0]              cpu_addr,
  input  logic [DATA_W-1:0]              cpu_wdata,
  input  logic [DATA_W/8-1:0]            cpu_wstrb,
  output logic [DATA_W-1:0]              cpu_rdata,
  output logic                           cpu_ready,
  output logic                           i_valid,
  output logic [ADDR_W-1:0]              i_addr,
  output logic [DATA_W-1:0]              i_wdata,
  output logic [DATA_W/8-1:0]            i_wstrb,
  input  logic [DATA_W-1:0]              i_rdata,
  input  logic                           i_ready,
  output logic [N_DPORTS-1:0]            d_valid,
  output logic [N_DPORTS*ADDR_W-1:0]     d_addr,
  output logic [N_DPORTS*DATA_W-1:0]     d_wdata,
  output logic [N_DPORTS*DATA_W/8-1:0]   d_wstrb,
  input  logic [N_DPORTS*DATA_W-1:0]     d_rdata,
  input  logic [N_DPORTS-1:0]            d_ready,
  output logic                           err,
  output logic [ADDR_W-1:0]              err_addr
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [SEL_W:0] NP = (SEL_W + 1)'(N_DPORTS);
  localparam logic [SEL_W-1:0] BOOT_IDX = SEL_W'(BOOT_PORT);
  logic [1:0]        state;
  logic              instr_q;
  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [SEL_W-1:0]  raw_idx;
  logic [SEL_W-1:0]  idx;
  logic              dec_err;
  logic              accept;
  logic              t_ready;
  logic [DATA_W-1:0] t_rdata;
  logic              expire;
  logic              set_err;
  logic [ADDR_W-1:0] fail_addr;

  assign raw_idx  = cpu_addr[ADDR_W-1 -: SEL_W];
  assign idx      = (boot && raw_idx == '0) ? BOOT_IDX : raw_idx;
  assign dec_err  = !cpu_instr && {1'b0, idx} >= NP;
  assign accept   = state == IDLE && cpu_valid && !cpu_ready;

  assign cpu_ready = state == RESP;
  assign i_valid   = state == WAIT && instr_q;
  assign i_addr    = addr_q;
  assign i_wdata   = wdata_q;
  assign i_wstrb   = wstrb_q;
  assign d_addr    = {N_DPORTS{addr_q}};
  assign d_wdata   = {N_DPORTS{wdata_q}};
  assign d_wstrb   = {N_DPORTS{wstrb_q}};

  // route valid to the captured target and pick its ready/rdata; other ports stay idle
  always_comb begin
    t_ready = instr_q & i_ready;
    t_rdata = i_rdata;
    d_valid = '0;
    for (int k = 0; k < N_DPORTS; k++)
      if (!instr_q && sel == SEL_W'(k)) begin
        t_ready    = d_ready[k];
        t_rdata    = d_rdata[k*DATA_W +: DATA_W];
        d_valid[k] = state == WAIT;
      end
  end

  iob_native_split_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .clr    (state != WAIT),
    .en     (state == WAIT),
    .expire (expire)
  );

  // a ready on the same cycle as expiry wins, so real data is never discarded
  assign set_err   = (accept && dec_err) || (state == WAIT && !t_ready && expire);
  assign fail_addr = state == IDLE ? cpu_addr : addr_q;

  // request FSM: capture in IDLE, hold fields in WAIT, one-cycle response in RESP
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state     <= IDLE;
      instr_q   <= 1'b0;
      sel       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cpu_rdata <= '0;
    end else
      case (state)
        IDLE: if (accept) begin
          instr_q <= cpu_instr;
          sel     <= idx;
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
          wstrb_q <= cpu_wstrb;
          state   <= dec_err ? RESP : WAIT;
          if (dec_err) cpu_rdata <= ERR_RDATA;
        end
        WAIT: if (t_ready || expire) begin
          state     <= RESP;
          cpu_rdata <= t_ready ? t_rdata : ERR_RDATA;
        end
        default: state <= IDLE;
      endcase

  // sticky error keeps the first failing address; a new error beats a clear
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      err <= set_err || (err && !err_clr);
      if (set_err && !err) err_addr <= fail_addr;
    end
endmodule

// File: tb/tb_iob_native_split.sv
// tb_iob_native_split: directed vector bench for the native port splitter
module tb_iob_native_split;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic boot = 1'b0;
  logic err_clr = 1'b0;
  logic cpu_instr = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0] cpu_wstrb = '0;
  logic va = 1'b0;
  logic vb = 1'b0;
  logic [1:0] a_en = 2'b11;
  logic [1:0] a_late = 2'b00;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  logic [31:0] a_cpu_rdata, a_i_addr, a_i_wdata, a_err_addr, a_i_rdata;
  logic a_cpu_ready, a_i_valid, a_i_ready, a_err;
  logic [3:0] a_i_wstrb;
  logic [1:0] a_d_valid, a_d_ready;
  logic [63:0] a_d_addr, a_d_wdata, a_d_rdata;
  logic [7:0] a_d_wstrb;
  assign a_i_rdata = 32'h0000_0013;
  assign a_i_ready = a_i_valid;
  assign a_d_rdata = {32'h2222_0001, 32'h1111_0000};
  assign a_d_ready = (a_d_valid & a_en) | a_late;

  iob_native_split #(.N_DPORTS(2), .SEL_W(1), .BOOT_PORT(1), .TIMEOUT(4)) dut_a (
    .clk(clk), .resetn(resetn), .boot(boot), .err_clr(err_clr),
    .cpu_valid(va), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_rdata(a_cpu_rdata), .cpu_ready(a_cpu_ready),
    .i_valid(a_i_valid), .i_addr(a_i_addr), .i_wdata(a_i_wdata), .i_wstrb(a_i_wstrb),
    .i_rdata(a_i_rdata), .i_ready(a_i_ready),
    .d_valid(a_d_valid), .d_addr(a_d_addr), .d_wdata(a_d_wdata), .d_wstrb(a_d_wstrb),
    .d_rdata(a_d_rdata), .d_ready(a_d_ready), .err(a_err), .err_addr(a_err_addr)
  );

  logic [31:0] b_cpu_rdata, b_i_addr, b_i_wdata, b_err_addr, b_i_rdata;
  logic b_cpu_ready, b_i_valid, b_i_ready, b_err;
  logic [3:0] b_i_wstrb;
  logic [2:0] b_d_valid, b_d_ready;
  logic [95:0] b_d_addr, b_d_wdata, b_d_rdata;
  logic [11:0] b_d_wstrb;
  assign b_i_rdata = 32'h0000_0013;
  assign b_i_ready = b_i_valid;
  assign b_d_rdata = {32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
  assign b_d_ready = b_d_valid;

  iob_native_split #(.N_DPORTS(3), .SEL_W(2), .BOOT_PORT(1), .TIMEOUT(4)) dut_b (
    .clk(clk), .resetn(resetn), .boot(boot), .err_clr(err_clr),
    .cpu_valid(vb), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready),
    .i_valid(b_i_valid), .i_addr(b_i_addr), .i_wdata(b_i_wdata), .i_wstrb(b_i_wstrb),
    .i_rdata(b_i_rdata), .i_ready(b_i_ready),
    .d_valid(b_d_valid), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_wstrb(b_d_wstrb),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready), .err(b_err), .err_addr(b_err_addr)
  );

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bt;
    logic [3:0]  mask;
    int          lat;
    logic [31:0] rd;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // one CPU transaction on dut_a (b=0) or dut_b (b=1); seen = {d2,d1,d0,i} valids observed
  task automatic txn(input bit b, input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input logic bt, input logic clr,
                     output logic [3:0] seen, output int lat, output int vcyc, output logic [31:0] rd,
                     output logic [31:0] paddr, output logic [31:0] pwdata, output logic [3:0] pwstrb);
    logic [3:0] vm;
    @(negedge clk);
    cpu_instr = instr; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb; boot = bt; err_clr = clr;
    if (b) vb = 1'b1; else va = 1'b1;
    @(posedge clk);
    seen = '0; lat = 0; vcyc = 0; rd = '0; paddr = '0; pwdata = '0; pwstrb = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      err_clr = 1'b0;
      vm = b ? {b_d_valid, b_i_valid} : {1'b0, a_d_valid, a_i_valid};
      if (vm != 0) begin
        vcyc++;
        seen |= vm;
        paddr  = vm[0] ? (b ? b_i_addr : a_i_addr) : (b ? b_d_addr[31:0] : a_d_addr[31:0]);
        pwdata = vm[0] ? (b ? b_i_wdata : a_i_wdata) : (b ? b_d_wdata[31:0] : a_d_wdata[31:0]);
        pwstrb = vm[0] ? (b ? b_i_wstrb : a_i_wstrb) : (b ? b_d_wstrb[3:0] : a_d_wstrb[3:0]);
      end
      if (b ? b_cpu_ready : a_cpu_ready) begin
        lat = n;
        rd = b ? b_cpu_rdata : a_cpu_rdata;
        break;
      end
    end
    va = 1'b0; vb = 1'b0;
  endtask

  vec_t v[6];
  logic [3:0] seen, pws;
  int lat, vcyc;
  logic [31:0] rd, pa, pwd;
  bit bad;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    v[0] = '{1'b1, 32'h0000_0100, 32'h0,         4'h0, 1'b0, 4'b0001, 2, 32'h0000_0013};
    v[1] = '{1'b0, 32'h8000_0010, 32'hA5A5_A5A5, 4'hF, 1'b0, 4'b0100, 2, 32'h2222_0001};
    v[2] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 1'b1, 4'b0100, 2, 32'h2222_0001};
    v[3] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 1'b0, 4'b0010, 2, 32'h1111_0000};
    v[4] = '{1'b0, 32'h8000_0000, 32'h1234_5678, 4'h3, 1'b1, 4'b0100, 2, 32'h2222_0001};
    v[5] = '{1'b1, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 4'b0001, 2, 32'h0000_0013};

    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(negedge clk);
    chk("reset_valids", {a_d_valid, a_i_valid, a_cpu_ready}, '0);
    chk("reset_rdata", a_cpu_rdata, '0);
    chk("reset_err", {a_err, a_err_addr}, '0);

    for (int i = 0; i < 6; i++) begin
      txn(1'b0, v[i].instr, v[i].addr, v[i].wdata, v[i].wstrb, v[i].bt, 1'b0, seen, lat, vcyc, rd, pa, pwd, pws);
      chk($sformatf("v%0d_ports", i), seen, v[i].mask);
      chk($sformatf("v%0d_latency", i), lat, v[i].lat);
      chk($sformatf("v%0d_valid_cycles", i), vcyc, 1);
      chk($sformatf("v%0d_rdata", i), rd, v[i].rd);
      chk($sformatf("v%0d_port_addr", i), pa, v[i].addr);
      chk($sformatf("v%0d_port_wdata", i), pwd, v[i].wdata);
      chk($sformatf("v%0d_port_wstrb", i), pws, v[i].wstrb);
      chk($sformatf("v%0d_fanout", i), {a_d_addr[63:32], a_d_wdata[63:32], a_d_wstrb[7:4]},
          {a_d_addr[31:0], a_d_wdata[31:0], a_d_wstrb[3:0]});
      chk($sformatf("v%0d_err", i), a_err, 1'b0);
    end

    // watchdog: port 1 never answers
    a_en = 2'b01;
    txn(1'b0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 1'b0, 1'b0, seen, lat, vcyc, rd, pa, pwd, pws);
    chk("to_ports", seen, 4'b0100);
    chk("to_valid_cycles", vcyc, 4);
    chk("to_latency", lat, 5);
    chk("to_rdata", rd, 32'hDEAD_BEEF);
    chk("to_err", a_err, 1'b1);
    chk("to_err_addr", a_err_addr, 32'h8000_0020);
    a_late = 2'b10;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (a_cpu_ready || a_d_valid != 0) bad = 1'b1;
    end
    chk("late_ready_ignored", bad, 1'b0);
    a_late = 2'b00;
    a_en = 2'b11;
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    chk("err_clr", a_err, 1'b0);

    // decode errors on the 3-port instance
    txn(1'b1, 1'b0, 32'hC000_0000, 32'h0, 4'h0, 1'b0, 1'b0, seen, lat, vcyc, rd, pa, pwd, pws);
    chk("de_ports", seen, 4'b0000);
    chk("de_latency", lat, 1);
    chk("de_rdata", rd, 32'hDEAD_BEEF);
    chk("de_err", b_err, 1'b1);
    chk("de_err_addr", b_err_addr, 32'hC000_0000);
    txn(1'b1, 1'b0, 32'hC000_0100, 32'h0, 4'h0, 1'b0, 1'b0, seen, lat, vcyc, rd, pa, pwd, pws);
    chk("de2_latency", lat, 1);
    chk("de2_keep_first_addr", b_err_addr, 32'hC000_0000);
    txn(1'b1, 1'b0, 32'hC000_0200, 32'h0, 4'h0, 1'b0, 1'b1, seen, lat, vcyc, rd, pa, pwd, pws);
    chk("de3_set_beats_clr", b_err, 1'b1);
    chk("de3_keep_first_addr", b_err_addr, 32'hC000_0000);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    chk("b_err_clr", b_err, 1'b0);
    txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 1'b0, 1'b0, seen, lat, vcyc, rd, pa, pwd, pws);
    chk("b_port2_ports", seen, 4'b1000);
    chk("b_port2_rdata", rd, 32'h3333_0002);
    chk("b_port2_latency", lat, 2);
    txn(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 1'b1, 1'b0, seen, lat, vcyc, rd, pa, pwd, pws);
    chk("b_boot_ports", seen, 4'b0100);
    chk("b_boot_rdata", rd, 32'h2222_0001);
    txn(1'b1, 1'b0, 32'hC000_0300, 32'h0, 4'h0, 1'b0, 1'b0, seen, lat, vcyc, rd, pa, pwd, pws);
    chk("de4_new_err_addr", {b_err, b_err_addr}, {1'b1, 32'hC000_0300});

    // reset while waiting on a silent port 0
    a_en = 2'b10;
    @(negedge clk);
    cpu_instr = 1'b0; cpu_addr = 32'h0000_0008; boot = 1'b0; cpu_wstrb = 4'h0; va = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_wait_valid", a_d_valid, 2'b01);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_outputs", {a_d_valid, a_i_valid, a_cpu_ready}, '0);
    chk("async_reset_rdata", a_cpu_rdata, '0);
    va = 1'b0;
    a_en = 2'b11;
    @(negedge clk) resetn = 1'b1;
    txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b0, seen, lat, vcyc, rd, pa, pwd, pws);
    chk("post_reset_ports", seen, 4'b0010);
    chk("post_reset_latency", lat, 2);
    chk("post_reset_rdata", rd, 32'h1111_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
